fft_frame_feeder: RTL and testbench
===================================

// Module: fft_frame_feeder
// PURPOSE
//   Parametrised ADC-to-FFT framer for the oscilloscope path. Buffers ADC samples in a small FIFO,
//   cuts them into frames of FRAME_LEN and drives a complex AXI4-Stream master (real = sample,
//   imag = 0) with tlast on the last beat. Supports single-shot/continuous capture, respects tready
//   backpressure, reports overflow. Sits between the ADC front end and the FFT core, both on clk.
// PARAMETERS
//   DATA_W      8     ADC sample width
//   OUT_W       16    width of each of real/imag in m_tdata; must satisfy OUT_W >= DATA_W
//   FRAME_LEN   256   samples per frame; >= 2
//   FIFO_DEPTH  16    sample FIFO depth; power of two, >= 2
// PORTS
//   clk         in   1         single clock (ADC and FFT side)
//   rst         in   1         asynchronous, active-high reset
//   en          in   1         capture enable; low = stop after padding current frame
//   mode        in   1         0 = single-shot, 1 = continuous
//   start       in   1         one-cycle pulse: arm capture, clear overflow
//   adc_data    in   DATA_W    ADC sample
//   adc_valid   in   1         adc_data valid this cycle
//   m_tdata     out  2*OUT_W   {imag[OUT_W-1:0], real[OUT_W-1:0]}
//   m_tvalid    out  1         AXI4-S valid
//   m_tready    in   1         AXI4-S ready
//   m_tlast     out  1         last beat of frame
//   busy        out  1         state != IDLE
//   frame_done  out  1         one-cycle pulse on tlast handshake
//   overflow    out  1         sticky: sample dropped because FIFO full
//   frame_cnt   out  16        completed frames, wraps 0xFFFF -> 0
// BEHAVIOUR
//   Reset: all outputs 0, FIFO empty, state IDLE, counters 0.
//   States: IDLE, CAPTURE, PAD, DRAIN.
//   IDLE -> CAPTURE on start & en. start while busy is ignored.
//   CAPTURE: each adc_valid with FIFO not full writes one sample, wr_idx++. Write of wr_idx==FRAME_LEN-1
//     -> DRAIN. adc_valid with FIFO full: sample dropped, not counted, overflow<=1.
//     en low -> PAD (sample on that cycle still written if adc_valid).
//   PAD: writes one zero sample per cycle when FIFO not full, ignoring adc_valid, until frame holds
//     FRAME_LEN samples -> DRAIN. Every frame reaches the core complete, with tlast.
//   DRAIN: no writes; on tlast handshake -> CAPTURE if mode & en, else IDLE.
//   Continuous: next frame's samples are accepted from the cycle after the tlast handshake.
//   Output: registered FIFO read stage; sample written in cycle N is on m_tdata no earlier than N+1.
//     m_tvalid held, m_tdata/m_tlast stable until m_tready. Never retracted without handshake.
//   m_tlast = 1 on output beat index FRAME_LEN-1 (rd_idx counter, wraps to 0 on tlast handshake).
//   On tlast handshake: frame_done pulses next cycle, frame_cnt++.
//   Simultaneous FIFO write and read when full: the read frees the slot; the write succeeds.
//   overflow cleared only by start (accepted) or rst; set wins over clear in the same cycle.
//   Imag half of m_tdata is always 0. rst mid-frame aborts immediately: FIFO flushed, m_tvalid 0.
// CONFIGURATION
//   OFFSET_BIN_EN defined: ADC is offset-binary. real = {~s[DATA_W-1], s[DATA_W-2:0],
//     (OUT_W-DATA_W)'b0} (signed, left-justified). PAD zero samples give real = 0.
//   Not defined: real = {(OUT_W-DATA_W)'b0, s} (unsigned, right-justified).
// TESTING
//   FRAME_LEN=8, mode=0, tready=1, ramp 0..7 -> 8 beats real=0..7, tlast on beat 8 only,
//     frame_done once, frame_cnt=1, busy low afterwards.
//   Same, tready toggling 1/0 per cycle -> identical 8 beats, tdata/tlast stable while stalled,
//     no overflow.
//   FIFO_DEPTH=4, tready=0, 6 adc_valid in CAPTURE -> overflow=1, 4 samples kept;
//     release tready -> frame completes with FRAME_LEN beats, overflow still 1; next start clears it.
//   en dropped after 3 samples (5,6,7) -> beats 5,6,7,0,0,0,0,0 with tlast on beat 8, then IDLE.
//   mode=1, en held, continuous ramp -> back-to-back frames, frame_cnt 1,2,3, no lost sample when
//     tready=1.
//   OFFSET_BIN_EN, DATA_W=8, OUT_W=16: 0x80 -> real 0x0000, 0x00 -> 0x8000, 0xFF -> 0x7F00.

Source files
------------

// File: rtl/fft_frame_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fft_frame_feeder                                         |
// | Brief    : Buffers ADC samples, cuts them into FRAME_LEN frames and   |
// |            drives a complex AXI4-Stream master (imag = 0, tlast).    |
// |            Macro OFFSET_BIN_EN: offset-binary ADC, signed left-justified output. |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module fft_frame_feeder #(
    parameter int DATA_W     = 8,
    parameter int OUT_W      = 16,
    parameter int FRAME_LEN  = 256,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic                start,
    input  logic [DATA_W-1:0]   adc_data,
    input  logic                adc_valid,
    output logic [2*OUT_W-1:0]  m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast,
    output logic                busy,
    output logic                frame_done,
    output logic                overflow,
    output logic [15:0]         frame_cnt
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(FRAME_LEN - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CAPTURE = 2'd1;
    localparam logic [1:0] c_PAD     = 2'd2;
    localparam logic [1:0] c_DRAIN   = 2'd3;

    logic [1:0]          r_state;
    logic [OUT_W-1:0]    r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_IDX_W-1:0]  r_wr_idx;
    logic [c_IDX_W-1:0]  r_beat_idx;
    logic                r_tvalid;
    logic                r_tlast;
    logic [OUT_W-1:0]    r_real;
    logic                r_frame_done;
    logic                r_overflow;
    logic [15:0]         r_frame_cnt;

    logic [DATA_W-1:0]   w_adj;
    logic [OUT_W-1:0]    w_fmt;
    logic [OUT_W-1:0]    w_wr_data;
    logic                w_hs;
    logic                w_last_hs;
    logic                w_load;
    logic                w_full;
    logic                w_can_write;
    logic                w_wr_req;
    logic                w_wr;
    logic                w_drop;
    logic                w_start_ok;

    // Sample formatting: offset-binary becomes two's complement by flipping the MSB.
`ifdef OFFSET_BIN_EN
    localparam logic [DATA_W-1:0] c_MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};
    assign w_adj = adc_data ^ c_MSB_MASK;
`else
    assign w_adj = adc_data;
`endif

    generate
        if (OUT_W > DATA_W) begin : g_widen
`ifdef OFFSET_BIN_EN
            assign w_fmt = {w_adj, {(OUT_W-DATA_W){1'b0}}};
`else
            assign w_fmt = {{(OUT_W-DATA_W){1'b0}}, w_adj};
`endif
        end else begin : g_same
            assign w_fmt = w_adj;
        end
    endgenerate

    // The output register counts toward capacity, so FIFO_DEPTH samples total can be held.
    assign w_hs        = r_tvalid & m_tready;
    assign w_last_hs   = w_hs & r_tlast;
    assign w_load      = (~r_tvalid | m_tready) & (r_count != '0);
    assign w_full      = (r_count + c_CNT_W'(r_tvalid)) == c_DEPTH;
    assign w_can_write = ~w_full | w_hs;
    assign w_wr_req    = ((r_state == c_CAPTURE) & adc_valid) | (r_state == c_PAD);
    assign w_wr        = w_wr_req & w_can_write;
    assign w_wr_data   = (r_state == c_PAD) ? '0 : w_fmt;
    assign w_drop      = (r_state == c_CAPTURE) & adc_valid & ~w_can_write;
    assign w_start_ok  = (r_state == c_IDLE) & start & en;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    // Control, FIFO pointers and the output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_wr_idx     <= '0;
            r_beat_idx   <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_real       <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_start_ok) begin
                        r_state  <= c_CAPTURE;
                        r_wr_idx <= '0;
                    end
                end
                c_CAPTURE, c_PAD: begin
                    if (w_wr && (r_wr_idx == c_LAST_IDX)) begin
                        r_state  <= c_DRAIN;
                        r_wr_idx <= '0;
                    end else begin
                        if (w_wr) begin
                            r_wr_idx <= r_wr_idx + c_IDX_W'(1);
                        end
                        if ((r_state == c_CAPTURE) && !en) begin
                            r_state <= c_PAD;
                        end
                    end
                end
                default: begin
                    if (w_last_hs) begin
                        r_state <= (mode && en) ? c_CAPTURE : c_IDLE;
                    end
                end
            endcase

            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end

            case ({w_wr, w_load})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // Beat index is tracked at load time so tlast travels with its data.
            if (w_load) begin
                r_real     <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + c_PTR_W'(1);
                r_tvalid   <= 1'b1;
                r_tlast    <= (r_beat_idx == c_LAST_IDX);
                r_beat_idx <= (r_beat_idx == c_LAST_IDX) ? '0 : r_beat_idx + c_IDX_W'(1);
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end

            r_frame_done <= w_last_hs;
            if (w_last_hs) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_start_ok) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign m_tdata    = {{OUT_W{1'b0}}, r_real};
    assign m_tvalid   = r_tvalid;
    assign m_tlast    = r_tlast;
    assign busy       = (r_state != c_IDLE);
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_feeder.sv
`default_nettype none
// Bench for fft_frame_feeder: random and directed frames checked against a
// queue-based reference built from the framing rules.
module tb_fft_frame_feeder;

    localparam int DATA_W     = 8;
    localparam int OUT_W      = 16;
    localparam int FRAME_LEN  = 8;
    localparam int FIFO_DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               mode = 1'b0;
    logic               start = 1'b0;
    logic [DATA_W-1:0]  adc_data = '0;
    logic               adc_valid = 1'b0;
    logic               m_tready = 1'b0;
    logic [2*OUT_W-1:0] m_tdata;
    logic               m_tvalid;
    logic               m_tlast;
    logic               busy;
    logic               frame_done;
    logic               overflow;
    logic [15:0]        frame_cnt;

    fft_frame_feeder #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start),
        .adc_data(adc_data), .adc_valid(adc_valid),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .busy(busy), .frame_done(frame_done), .overflow(overflow), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int exp_fc = 0;
    logic [OUT_W-1:0] exp_q[$];

    logic [OUT_W-1:0] beat_q[$];
    logic             last_q[$];
    logic [15:0]      fc_q[$];
    int               stall_err = 0;
    int               imag_err = 0;
    int               pulse_err = 0;
    logic             prev_stall = 1'b0;
    logic             prev_last_hs = 1'b0;
    logic [2*OUT_W-1:0] prev_data = '0;
    logic             prev_tl = 1'b0;

    // Passive monitor: records accepted beats and protocol anomalies.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall   <= 1'b0;
            prev_last_hs <= 1'b0;
        end else begin
            if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_tl))
                stall_err <= stall_err + 1;
            if (m_tvalid && m_tdata[2*OUT_W-1:OUT_W] !== '0)
                imag_err <= imag_err + 1;
            if (frame_done !== prev_last_hs)
                pulse_err <= pulse_err + 1;
            if (frame_done)
                fc_q.push_back(frame_cnt);
            if (m_tvalid && m_tready) begin
                beat_q.push_back(m_tdata[OUT_W-1:0]);
                last_q.push_back(m_tlast);
            end
            prev_stall   <= m_tvalid && !m_tready;
            prev_data    <= m_tdata;
            prev_tl      <= m_tlast;
            prev_last_hs <= m_tvalid && m_tready && m_tlast;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference formatting computed arithmetically from the sample value.
    function automatic logic [OUT_W-1:0] fmt(input logic [DATA_W-1:0] s);
`ifdef OFFSET_BIN_EN
        int v;
        v = int'(s) - (1 << (DATA_W-1));
        return OUT_W'(v * (1 << (OUT_W-DATA_W)));
`else
        return OUT_W'(s);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        beat_q.delete();
        last_q.delete();
        fc_q.delete();
        exp_q.delete();
    endtask

    task automatic start_frame();
        en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin
            tick();
            n++;
        end
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks += 6;
        if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b required 0", m_tvalid); end
        if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b required 0", m_tlast); end
        if (m_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %h required 0", m_tdata); end
        if (busy !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b required 00", busy, frame_done); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_shot();
        logic [DATA_W-1:0] s;
        clear_q();
        mode = 1'b0;
        m_tready = 1'b1;
        start_frame();
        for (int i = 0; i < FRAME_LEN; i++) begin
            s = DATA_W'($urandom);
            exp_q.push_back(fmt(s));
            repeat ($urandom_range(0, 2)) tick();
            adc_valid = 1'b1;
            adc_data = s;
            tick();
            adc_valid = 1'b0;
        end
        wait_idle("single");
        exp_fc++;
        n_checks++;
        if (beat_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL single_len: got %0d beats required %0d", beat_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (beat_q[i] !== exp_q[i] || last_q[i] !== (i == FRAME_LEN-1)) begin
                    n_fail++;
                    $display("FAIL single_beat%0d: got %h last %b required %h last %b",
                             i, beat_q[i], last_q[i], exp_q[i], (i == FRAME_LEN-1));
                end
            end
        end
        n_checks += 3;
        if (fc_q.size() !== 1) begin n_fail++; $display("FAIL single_done: got %0d pulses required 1", fc_q.size()); end
        if (frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL single_frame_cnt: got %0d required %0d", frame_cnt, exp_fc); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL single_overflow: got %b required 0", overflow); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] smp[FRAME_LEN];
        int k = 0;
        clear_q();
        mode = 1'b0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            smp[i] = DATA_W'($urandom);
            exp_q.push_back(fmt(smp[i]));
        end
        m_tready = 1'b1;
        start_frame();
        for (int c = 0; c < 400 && (k < FRAME_LEN || busy); c++) begin
            m_tready = (c % 2) == 1;
            if (k < FRAME_LEN && (c % 2) == 0) begin
                adc_valid = 1'b1;
                adc_data = smp[k];
                k++;
            end else begin
                adc_valid = 1'b0;
            end
            tick();
        end
        adc_valid = 1'b0;
        m_tready = 1'b1;
        wait_idle("bp");
        exp_fc++;
        n_checks++;
        if (beat_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_len: got %0d beats required %0d", beat_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (beat_q[i] !== exp_q[i] || last_q[i] !== (i == FRAME_LEN-1)) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d: got %h last %b required %h", i, beat_q[i], last_q[i], exp_q[i]);
                end
            end
        end
        n_checks += 3;
        if (stall_err !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d stall changes required 0", stall_err); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_overflow: got %b required 0", overflow); end
        if (frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL bp_frame_cnt: got %0d required %0d", frame_cnt, exp_fc); end
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] s;
        clear_q();
        mode = 1'b0;
        m_tready = 1'b0;
        start_frame();
        // Six back-to-back samples against a stalled sink: only FIFO_DEPTH survive.
        for (int i = 0; i < 6; i++) begin
            s = DATA_W'($urandom);
            if (i < FIFO_DEPTH) exp_q.push_back(fmt(s));
            adc_valid = 1'b1;
            adc_data = s;
            tick();
        end
        adc_valid = 1'b0;
        n_checks += 2;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b required 1", overflow); end
        if (beat_q.size() !== 0) begin n_fail++; $display("FAIL ovf_stalled: got %0d beats required 0", beat_q.size()); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_busy_start: got %b required 1", overflow); end
        m_tready = 1'b1;
        for (int i = FIFO_DEPTH; i < FRAME_LEN; i++) begin
            s = DATA_W'($urandom);
            exp_q.push_back(fmt(s));
            adc_valid = 1'b1;
            adc_data = s;
            tick();
        end
        adc_valid = 1'b0;
        wait_idle("ovf");
        exp_fc++;
        n_checks++;
        if (beat_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL ovf_len: got %0d beats required %0d", beat_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (beat_q[i] !== exp_q[i] || last_q[i] !== (i == FRAME_LEN-1)) begin
                    n_fail++;
                    $display("FAIL ovf_beat%0d: got %h last %b required %h", i, beat_q[i], last_q[i], exp_q[i]);
                end
            end
        end
        n_checks += 2;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
        if (frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL ovf_frame_cnt: got %0d required %0d", frame_cnt, exp_fc); end
    endtask

    task automatic test_start_clears();
        clear_q();
        m_tready = 1'b1;
        start_frame();
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %b required 0", overflow); end
        // en low right away: the whole frame is padding.
        en = 1'b0;
        wait_idle("clr");
        exp_fc++;
        n_checks += 2;
        if (beat_q.size() !== FRAME_LEN) begin
            n_fail++;
            $display("FAIL clr_len: got %0d beats required %0d", beat_q.size(), FRAME_LEN);
        end else begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                n_checks++;
                if (beat_q[i] !== '0 || last_q[i] !== (i == FRAME_LEN-1)) begin
                    n_fail++;
                    $display("FAIL clr_beat%0d: got %h last %b required 0", i, beat_q[i], last_q[i]);
                end
            end
        end
        if (frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL clr_frame_cnt: got %0d required %0d", frame_cnt, exp_fc); end
        en = 1'b1;
    endtask

    task automatic test_en_drop();
        logic [DATA_W-1:0] vals[3] = '{8'd5, 8'd6, 8'd7};
        clear_q();
        mode = 1'b0;
        m_tready = 1'b1;
        start_frame();
        for (int i = 0; i < 3; i++) begin
            adc_valid = 1'b1;
            adc_data = vals[i];
            en = (i != 2);
            exp_q.push_back(fmt(vals[i]));
            tick();
        end
        for (int i = 3; i < FRAME_LEN; i++) exp_q.push_back('0);
        // Samples offered during padding must be ignored.
        adc_data = 8'hA5;
        tick();
        tick();
        adc_valid = 1'b0;
        wait_idle("endrop");
        exp_fc++;
        n_checks += 2;
        if (beat_q.size() !== FRAME_LEN) begin
            n_fail++;
            $display("FAIL endrop_len: got %0d beats required %0d", beat_q.size(), FRAME_LEN);
        end else begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                n_checks++;
                if (beat_q[i] !== exp_q[i] || last_q[i] !== (i == FRAME_LEN-1)) begin
                    n_fail++;
                    $display("FAIL endrop_beat%0d: got %h last %b required %h", i, beat_q[i], last_q[i], exp_q[i]);
                end
            end
        end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL endrop_idle: got busy %b required 0", busy); end
        en = 1'b1;
    endtask

    task automatic test_format();
        logic [DATA_W-1:0] vals[3] = '{8'h80, 8'h00, 8'hFF};
`ifdef OFFSET_BIN_EN
        logic [OUT_W-1:0] req[3] = '{16'h0000, 16'h8000, 16'h7F00};
`else
        logic [OUT_W-1:0] req[3] = '{16'h0080, 16'h0000, 16'h00FF};
`endif
        clear_q();
        m_tready = 1'b1;
        start_frame();
        for (int i = 0; i < 3; i++) begin
            adc_valid = 1'b1;
            adc_data = vals[i];
            en = (i != 2);
            tick();
        end
        adc_valid = 1'b0;
        wait_idle("fmt");
        exp_fc++;
        n_checks++;
        if (beat_q.size() !== FRAME_LEN) begin
            n_fail++;
            $display("FAIL fmt_len: got %0d beats required %0d", beat_q.size(), FRAME_LEN);
        end else begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                n_checks++;
                if (beat_q[i] !== ((i < 3) ? req[i] : '0)) begin
                    n_fail++;
                    $display("FAIL fmt_beat%0d: got %h required %h", i, beat_q[i], (i < 3) ? req[i] : '0);
                end
            end
        end
        en = 1'b1;
    endtask

    task automatic test_continuous();
        int r = 0;
        int c = 0;
        int prev_end = -1;
        clear_q();
        mode = 1'b1;
        m_tready = 1'b1;
        start_frame();
        while (fc_q.size() < 3 && c < 300) begin
            adc_valid = 1'b1;
            adc_data = DATA_W'(r);
            r++;
            c++;
            tick();
        end
        adc_valid = 1'b1;
        adc_data = DATA_W'(r);
        r++;
        en = 1'b0;
        tick();
        adc_valid = 1'b0;
        wait_idle("cont");
        mode = 1'b0;
        en = 1'b1;
        n_checks += 3;
        if (fc_q.size() !== 4) begin
            n_fail++;
            $display("FAIL cont_frames: got %0d frames required 4", fc_q.size());
        end else begin
            for (int f = 0; f < 4; f++) begin
                n_checks++;
                if (fc_q[f] !== 16'(exp_fc + f + 1)) begin
                    n_fail++;
                    $display("FAIL cont_cnt%0d: got %0d required %0d", f, fc_q[f], exp_fc + f + 1);
                end
            end
        end
        exp_fc += 4;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL cont_overflow: got %b required 0", overflow); end
        if (beat_q.size() !== 4*FRAME_LEN) begin
            n_fail++;
            $display("FAIL cont_len: got %0d beats required %0d", beat_q.size(), 4*FRAME_LEN);
        end else begin
            // Each full frame must be an unbroken run of the ramp, frames in order.
            for (int f = 0; f < 3; f++) begin
                int j = -1;
                for (int v = 0; v < r; v++)
                    if (fmt(DATA_W'(v)) === beat_q[f*FRAME_LEN]) j = v;
                n_checks++;
                if (j <= prev_end || (f == 0 && j != 0)) begin
                    n_fail++;
                    $display("FAIL cont_order%0d: got start %0d required > %0d", f, j, prev_end);
                end
                for (int k = 0; k < FRAME_LEN; k++) begin
                    n_checks++;
                    if (beat_q[f*FRAME_LEN+k] !== fmt(DATA_W'(j+k)) || last_q[f*FRAME_LEN+k] !== (k == FRAME_LEN-1)) begin
                        n_fail++;
                        $display("FAIL cont_beat%0d_%0d: got %h required %h", f, k, beat_q[f*FRAME_LEN+k], fmt(DATA_W'(j+k)));
                    end
                end
                prev_end = j + FRAME_LEN - 1;
            end
        end
    endtask

    task automatic test_reset_midframe();
        clear_q();
        m_tready = 1'b0;
        start_frame();
        for (int i = 0; i < 3; i++) begin
            adc_valid = 1'b1;
            adc_data = DATA_W'($urandom);
            tick();
        end
        adc_valid = 1'b0;
        n_checks++;
        if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got tvalid %b required 1", m_tvalid); end
        rst = 1'b1;
        #1;
        n_checks += 2;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin n_fail++; $display("FAIL rstmid_tvalid: got %b%b required 00", m_tvalid, m_tlast); end
        if (busy !== 1'b0 || frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_state: got busy %b cnt %0d required 0 0", busy, frame_cnt); end
        tick();
        rst = 1'b0;
        exp_fc = 0;
        tick();
        test_single_shot();
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_backpressure();
        test_overflow();
        test_start_clears();
        test_en_drop();
        test_format();
        test_continuous();
        test_reset_midframe();
        n_checks += 2;
        if (imag_err !== 0) begin n_fail++; $display("FAIL imag_zero: got %0d nonzero beats required 0", imag_err); end
        if (pulse_err !== 0) begin n_fail++; $display("FAIL done_pulse: got %0d misplaced pulses required 0", pulse_err); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
